// File: rtl/key_evt_pkg.sv
// Shared constants and bit-vector helpers for the key event queue.
// The helpers are sized for the default NKEYS_DEF/CODE_W_DEF geometry.
package key_evt_pkg;

    localparam int NKEYS_DEF  = 16;
    localparam int CODE_W_DEF = 4;

    // Isolates the lowest set bit (two's-complement trick).
    function automatic logic [NKEYS_DEF-1:0] lowest_onehot(input logic [NKEYS_DEF-1:0] v);
        return v & (~v + NKEYS_DEF'(1));
    endfunction

    function automatic logic [CODE_W_DEF-1:0] onehot2bin(input logic [NKEYS_DEF-1:0] v);
        logic [CODE_W_DEF-1:0] b;
        b = '0;
        for (int i = 0; i < NKEYS_DEF; i++) begin
            if (v[i]) b = b | CODE_W_DEF'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous show-ahead FIFO: rdata_o is the head entry, forced to 0 while empty.
module key_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key-press pulses into an ordered queue of key codes (lowest index wins ties).
// Optional KEY_EVENT_DROP_CNT_EN adds a saturating lost-press counter on drop_cnt.
module key_event_queue
    import key_evt_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int NKEYS  = NKEYS_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NKEYS-1:0]           key_in,
    output logic [CODE_W-1:0]          evt_code,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overrun,
`ifdef KEY_EVENT_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    input  logic                       clr_overrun
);

    logic [NKEYS-1:0]  key_q;
    logic [NKEYS-1:0]  pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic [NKEYS-1:0]  key_rise, grant, lost;
    logic              pop, push, push_ok, fifo_full, fifo_empty;
    logic [CODE_W-1:0] push_code;

    assign pop     = evt_valid && evt_ready;
    assign push_ok = !fifo_full || pop;

    always_comb begin
        key_rise  = key_in & ~key_q;
        grant     = push_ok ? lowest_onehot(pending_q) : '0;
        push      = |grant;
        push_code = onehot2bin(grant);
        // A rise on a bit still waiting (and not leaving this cycle) merges and is lost.
        lost      = key_rise & pending_q & ~grant;
        pending_d = (pending_q & ~grant) | key_rise;
        overrun_d = overrun_q;
        if (|lost)            overrun_d = 1'b1;
        else if (clr_overrun) overrun_d = 1'b0;
    end

    // key_q keeps tracking key_in during reset so a key held across reset is not re-reported.
    always_ff @(posedge clk) begin
        key_q <= key_in;
        if (rst) begin
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    key_evt_fifo #(
        .DEPTH (DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_code),
        .pop_i   (pop),
        .rdata_o (evt_code),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign evt_valid = !fifo_empty;
    assign overrun   = overrun_q;

`ifdef KEY_EVENT_DROP_CNT_EN
    localparam int PW = $clog2(NKEYS+1);

    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] lost_cnt;
    logic [8:0]    drop_sum;

    // A clear and a loss in the same cycle leaves just this cycle's losses.
    always_comb begin
        lost_cnt = '0;
        for (int i = 0; i < NKEYS; i++) begin
            lost_cnt = lost_cnt + PW'(lost[i]);
        end
        drop_sum   = {1'b0, (clr_overrun ? 8'd0 : drop_cnt_q)} + 9'(lost_cnt);
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: directed scenarios plus randomized chords.
module tb_key_event_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key_in;
    logic [3:0]  evt_code;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  fifo_level;
    logic        overrun;
    logic        clr_overrun;
`ifdef KEY_EVENT_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    logic [3:0] exp_q[$];
    logic       hold_prev = 1'b0;
    logic [3:0] hold_code = '0;

    key_event_queue #(.DEPTH(8), .NKEYS(16), .CODE_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .evt_code    (evt_code),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .fifo_level  (fifo_level),
        .overrun     (overrun),
`ifdef KEY_EVENT_DROP_CNT_EN
        .drop_cnt    (drop_cnt),
`endif
        .clr_overrun (clr_overrun)
    );

    // Clock / reset infrastructure
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard whenever a handshake completes at the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_prev && evt_valid) begin
                checks++;
                if (evt_code !== hold_code) begin
                    errors++;
                    $display("FAIL hold_stable got %0d want %0d", evt_code, hold_code);
                end
            end
            if (evt_valid && evt_ready) begin
                checks++;
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event got code %0d want none", evt_code);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (evt_code !== e) begin
                        errors++;
                        $display("FAIL event_code got %0d want %0d", evt_code, e);
                    end
                end
            end
            hold_prev = evt_valid && !evt_ready;
            hold_code = evt_code;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Driver tasks
    task automatic press_single(input int k);
        key_in = 16'(1) << k;
        tick();
        key_in = '0;
        tick();
        exp_q.push_back(4'(k));
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        evt_ready = 1'b1;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left %0d want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) tick();
        check("level_after_drain", int'(fifo_level), 0);
    endtask

    initial begin
        rst = 1'b1;
        key_in = '0;
        evt_ready = 1'b0;
        clr_overrun = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_valid", int'(evt_valid), 0);
        check("reset_level", int'(fifo_level), 0);
        check("reset_code", int'(evt_code), 0);
        check("reset_overrun", int'(overrun), 0);
`ifdef KEY_EVENT_DROP_CNT_EN
        check("reset_drop_cnt", int'(drop_cnt), 0);
`endif

        // Single press held for 5 cycles gives one event
        evt_ready = 1'b1;
        pop_cnt = 0;
        exp_q.push_back(4'd5);
        key_in = 16'h0020;
        repeat (5) tick();
        key_in = '0;
        drain(50);
        check("single_event_count", pop_cnt, 1);
        check("single_overrun", int'(overrun), 0);

        // Chord queued under back-pressure
        evt_ready = 1'b0;
        key_in = 16'h8101;
        tick();
        key_in = '0;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd15);
        repeat (6) tick();
        check("chord_level", int'(fifo_level), 3);
        drain(50);

        // Full back-pressure: ten presses, eight queued, two pending
        evt_ready = 1'b0;
        for (int k = 0; k < 10; k++) press_single(k);
        repeat (3) tick();
        check("full_level", int'(fifo_level), 8);
        check("full_code", int'(evt_code), 0);
        check("full_valid", int'(evt_valid), 1);
        drain(100);
        check("full_overrun", int'(overrun), 0);

        // Overrun: key 3 pressed twice while stuck pending
        evt_ready = 1'b0;
        for (int k = 0; k < 8; k++) press_single(k);
        key_in = 16'h0008; tick();
        key_in = '0;       tick();
        key_in = 16'h0008; tick();
        key_in = '0;       tick();
        exp_q.push_back(4'd3);
        check("overrun_set", int'(overrun), 1);
`ifdef KEY_EVENT_DROP_CNT_EN
        check("drop_cnt_one", int'(drop_cnt), 1);
`endif
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        tick();
        check("overrun_clr", int'(overrun), 0);
`ifdef KEY_EVENT_DROP_CNT_EN
        check("drop_cnt_clr", int'(drop_cnt), 0);
`endif
        drain(100);

        // Push and pop together at full
        evt_ready = 1'b0;
        for (int k = 0; k < 8; k++) press_single(k);
        key_in = 16'h1000; tick();
        key_in = '0;       tick();
        tick();
        exp_q.push_back(4'd12);
        check("pp_level_before", int'(fifo_level), 8);
        evt_ready = 1'b1;
        tick();
        check("pp_level_after", int'(fifo_level), 8);
        drain(100);
        check("pp_overrun", int'(overrun), 0);

        // Reset mid-operation with key 6 held and key 9 just pending
        evt_ready = 1'b0;
        for (int k = 0; k < 3; k++) press_single(k);
        key_in = 16'h0040;
        repeat (3) tick();
        check("rst_level_before", int'(fifo_level), 4);
        key_in = 16'h0240;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("rst_valid", int'(evt_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        evt_ready = 1'b1;
        pop_cnt = 0;
        repeat (8) tick();
        check("rst_held_no_event", pop_cnt, 0);
        check("rst_level_held", int'(fifo_level), 0);
        key_in = '0;
        tick();
        key_in = 16'h0040;
        exp_q.push_back(4'd6);
        tick();
        key_in = '0;
        drain(50);

        // Randomized chords with random back-pressure; order is ascending index
        for (int it = 0; it < 40; it++) begin
            logic [15:0] chord;
            int n;
            chord = 16'($urandom_range(1, 16'hFFFF));
            for (int b = 0; b < 16; b++) begin
                if (chord[b]) exp_q.push_back(4'(b));
            end
            key_in = chord;
            evt_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) tick();
            key_in = '0;
            n = 0;
            while (exp_q.size() != 0 && n < 400) begin
                evt_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            drain(50);
        end
        check("random_overrun", int'(overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
